// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller. It handles load-use bubbles, branch flushes, memory-wait
// freezes, halt drain sequencing, a memory watchdog and a saturating stall counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_opcode,
    input  logic [3:0]  id_rs_reg,
    input  logic [3:0]  id_rt_reg,
    input  logic        id_uses_rt,
    input  logic [3:0]  ex_opcode,
    input  logic [3:0]  ex_rd,
    input  logic        ex_WriteReg,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_wen,
    output logic        if_id_wen,
    output logic        if_id_flush,
    output logic        id_ex_stall_n,
    output logic        id_ex_flush,
    output logic        ex_mem_wen,
    output logic        halted,
    output logic        mem_timeout,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_e;

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_e      state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic [7:0]  wd_q, wd_d;
    logic        timeout_q, timeout_d;
    logic [15:0] stall_q, stall_d;

    logic mem_stall;
    logic load_use;
    logic wd_hit;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = (ex_opcode == OP_LW) & ex_WriteReg & (ex_rd != 4'd0) &
                       ((ex_rd == id_rs_reg) | (id_uses_rt & (ex_rd == id_rt_reg)));

    // The 255th MEMWAIT cycle is the one entered with the watchdog already at 254.
    assign wd_hit = (state_q == MEMWAIT) & (wd_q == 8'd254);

    always_comb begin
        // NOTE: every output and next-state value is defaulted first with blocking
        // assignments, so no path through the case below can infer a latch.
        state_d       = state_q;
        drain_d       = drain_q;
        wd_d          = wd_q;
        pc_wen        = 1'b1;
        if_id_wen     = 1'b1;
        id_ex_stall_n = 1'b1;
        ex_mem_wen    = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        halted        = 1'b0;

        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        pc_wen        = 1'b0;
                        if_id_wen     = 1'b0;
                        id_ex_stall_n = 1'b0;
                        ex_mem_wen    = 1'b0;
                        state_d       = MEMWAIT;
                        wd_d          = 8'd0;
                    end else if (load_use) begin
                        pc_wen      = 1'b0;
                        if_id_wen   = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (branch_taken) begin
                        if_id_flush = 1'b1;
                    end else if (id_opcode == OP_HLT) begin
                        pc_wen      = 1'b0;
                        if_id_flush = 1'b1;
                        state_d     = DRAIN;
                        drain_d     = 2'd0;
                    end
                end

                MEMWAIT: begin
                    if (!mem_ready) begin
                        pc_wen        = 1'b0;
                        if_id_wen     = 1'b0;
                        id_ex_stall_n = 1'b0;
                        ex_mem_wen    = 1'b0;
                        if (wd_q != 8'hFF) wd_d = wd_q + 8'd1;
                    end else begin
                        // The release cycle may still need a load-use bubble.
                        state_d = RUN;
                        wd_d    = 8'd0;
                        if (load_use) begin
                            pc_wen      = 1'b0;
                            if_id_wen   = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    pc_wen      = 1'b0;
                    if_id_flush = 1'b1;
                    if (mem_stall) begin
                        if_id_wen     = 1'b0;
                        id_ex_stall_n = 1'b0;
                        ex_mem_wen    = 1'b0;
                    end else begin
                        drain_d = drain_q + 2'd1;
                        if (drain_q == 2'd2) state_d = HALTED;
                    end
                end

                HALTED: begin
                    pc_wen        = 1'b0;
                    if_id_wen     = 1'b0;
                    id_ex_stall_n = 1'b0;
                    ex_mem_wen    = 1'b0;
                    halted        = 1'b1;
                end

                default: state_d = RUN;
            endcase
        end
    end

    assign timeout_d   = timeout_q | wd_hit;
    assign mem_timeout = timeout_q | wd_hit;
    assign stall_count = stall_q;

    always_comb begin
        stall_d = stall_q;
        if (!pc_wen && (state_q != HALTED) && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            drain_q   <= 2'd0;
            wd_q      <= 8'd0;
            timeout_q <= 1'b0;
            stall_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

endmodule
